unpool_stream: RTL and testbench

//  Streaming 2-D unpooling (upsampling). This is the inverse direction of the max-pooling stage.
//  - Consumes a pooled map of (MAP_SIZE/STRIDE)^2 pixels, one pixel per handshake, in raster order.
//  - Emits the full MAP_SIZE x MAP_SIZE map in raster order.
//  - Each input pixel expands into a STRIDE x STRIDE block.
//  - Sits between the pooled-feature buffer and the upsampling/deconvolution path.

---
 rtl/unpool_stream.sv | 163 ++++++++++++++++
 tb/tb_unpool_stream.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unpool_stream.sv
// unpool_stream: streaming 2-D unpooling; each pooled pixel becomes a STRIDE x STRIDE output block, raster order.
// Optional macro MAX_UNPOOL_IDX_EN: max-unpooling with a stored argmax index (default: nearest-neighbour).
module unpool_stream #(
  parameter  int unsigned BUF_WIDTH = 26,
  parameter  int unsigned MAP_SIZE  = 32,
  parameter  int unsigned STRIDE    = 2,
  localparam int unsigned IDX_W     = $clog2(STRIDE * STRIDE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUF_WIDTH-1:0] in_data,
  input  logic [IDX_W-1:0]     in_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUF_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 done
);

  localparam int unsigned NPIX = MAP_SIZE / STRIDE;
  localparam int unsigned CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned HW   = $clog2(STRIDE);
`ifdef MAX_UNPOOL_IDX_EN
  localparam int unsigned ENT_W = IDX_W + BUF_WIDTH;
`else
  localparam int unsigned ENT_W = BUF_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, ROW_FILL, ROW_REPLAY, DRAIN} state_t;

  state_t               state;
  logic [HW-1:0]        hx;
  logic [HW-1:0]        ry;
  logic [CW-1:0]        col;
  logic [CW-1:0]        prow;
  logic [ENT_W-1:0]     lbuf [NPIX];

  logic                 free_c;
  logic                 take_c;
  logic                 emit_c;
  logic                 hx_end_c;
  logic                 col_end_c;
  logic                 ry_end_c;
  logic                 prow_end_c;
  logic                 last_pix_c;
  logic [ENT_W-1:0]     src_c;
  logic [BUF_WIDTH-1:0] pix_c;

  assign free_c   = !out_valid || out_ready;
  assign in_ready = (state == ROW_FILL) && (hx == '0) && free_c;
  assign take_c   = in_ready && in_valid;

  // The fill row takes a new pixel at hx==0 and repeats it from the line buffer for hx>0.
  assign emit_c = take_c ||
                  (free_c && (((state == ROW_FILL) && (hx != '0)) || (state == ROW_REPLAY)));

  assign hx_end_c   = (hx == HW'(STRIDE - 1));
  assign col_end_c  = (col == CW'(NPIX - 1));
  assign ry_end_c   = (ry == HW'(STRIDE - 1));
  assign prow_end_c = (prow == CW'(NPIX - 1));
  assign last_pix_c = (state == ROW_REPLAY) && ry_end_c && prow_end_c && col_end_c && hx_end_c;

`ifdef MAX_UNPOOL_IDX_EN
  assign src_c = take_c ? {in_idx, in_data} : lbuf[col];

  // Only the argmax position of each block carries the value.
  always_comb begin
    pix_c = '0;
    if (src_c[ENT_W-1 -: IDX_W] == IDX_W'(ry * STRIDE + hx))
      pix_c = src_c[BUF_WIDTH-1:0];
  end
`else
  logic unused_idx;

  assign unused_idx = ^in_idx;
  assign src_c      = take_c ? in_data : lbuf[col];
  assign pix_c      = src_c;
`endif

  always_ff @(posedge clk) begin
    if (take_c)
      lbuf[col] <= src_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      hx        <= '0;
      ry        <= '0;
      col       <= '0;
      prow      <= '0;
    end else begin
      done <= 1'b0;

      // Output register reloads whenever its slot is free (back-to-back without a bubble).
      if (free_c) begin
        out_valid <= emit_c;
        out_last  <= emit_c && last_pix_c;
        if (emit_c)
          out_data <= pix_c;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= ROW_FILL;
            busy  <= 1'b1;
          end
        end

        ROW_FILL, ROW_REPLAY: begin
          if (emit_c) begin
            if (!hx_end_c) begin
              hx <= hx + HW'(1);
            end else begin
              hx <= '0;
              if (!col_end_c) begin
                col <= col + CW'(1);
              end else begin
                col <= '0;
                if (state == ROW_FILL) begin
                  state <= ROW_REPLAY;
                  ry    <= HW'(1);
                end else if (!ry_end_c) begin
                  ry <= ry + HW'(1);
                end else begin
                  ry <= '0;
                  if (prow_end_c) begin
                    prow  <= '0;
                    state <= DRAIN;
                  end else begin
                    prow  <= prow + CW'(1);
                    state <= ROW_FILL;
                  end
                end
              end
            end
          end
        end

        DRAIN: begin
          if (out_valid && out_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unpool_stream.sv
// tb_unpool_stream: directed frames on a 4x4 map (stride 2) checked against a per-pixel model of the upsampled map.
`timescale 1ns/1ps
module tb_unpool_stream;

  localparam int unsigned BW   = 26;
  localparam int unsigned MS   = 4;
  localparam int unsigned ST   = 2;
  localparam int unsigned NP   = MS / ST;
  localparam int unsigned NIN  = NP * NP;
  localparam int unsigned NOUT = MS * MS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic [1:0]    in_idx;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic          out_last;
  logic          done;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [BW:0]   exp_q [$];
  logic [BW-1:0] got_q [$];
  logic [BW:0]   e;
  logic [BW-1:0] vals [NIN];
  logic [1:0]    idxs [NIN];

  int in_cnt, out_cnt, first_in_cyc, first_valid_cyc, first_out_cyc, last_out_cyc;
  bit exp_done   = 1'b0;
  bit frame_done = 1'b0;
  bit have_prev  = 1'b0;
  bit ready_rand = 1'b0;
  logic [BW-1:0] prev_data;
  logic          prev_last;
  logic [31:0]   ready_pat = 32'hB5A3_6C9D;

  int t1_lit [NOUT] = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
  int t4_lit [NOUT] = '{9, 9, 8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int t5_lit [NOUT] = '{0, 0, 6, 0, 0, 5, 0, 0, 0, 7, 0, 0, 0, 0, 8, 0};
  int t6_lit [NOUT] = '{default: 26'h3FF_FFFF};

  unpool_stream #(.BUF_WIDTH(BW), .MAP_SIZE(MS), .STRIDE(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = ready_rand ? ready_pat[cyc % 32] : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Expected map: pixel (y,x) comes from pooled pixel (y/ST, x/ST).
  function automatic void build_expect();
    exp_q.delete();
    for (int y = 0; y < MS; y++) begin
      for (int x = 0; x < MS; x++) begin
        int p;
        logic [BW-1:0] v;
        p = (y / ST) * NP + x / ST;
`ifdef MAX_UNPOOL_IDX_EN
        v = (int'(idxs[p]) == (y % ST) * ST + (x % ST)) ? vals[p] : '0;
`else
        v = vals[p];
`endif
        exp_q.push_back({1'((y == MS - 1) && (x == MS - 1)), v});
      end
    end
  endfunction

  // Per-cycle monitor: scoreboard, stall stability, done pulse.
  always @(negedge clk) begin
    if (rst) begin
      have_prev = 1'b0;
      exp_done  = 1'b0;
    end else begin
      chk("done_pulse", done, exp_done);
      if (exp_done) begin
        chk("busy_clear_at_done", busy, 0);
        frame_done = 1'b1;
      end
      exp_done = 1'b0;
      if (have_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      have_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (in_valid && in_ready) begin
        in_cnt++;
        if (first_in_cyc < 0) first_in_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        got_q.push_back(out_data);
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got data %0h, expected no output", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e[BW-1:0]);
          chk("out_last", out_last, e[BW]);
          if (e[BW]) exp_done = 1'b1;
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
  endtask

  task automatic start_frame();
    in_cnt = 0; out_cnt = 0; got_q.delete(); frame_done = 1'b0;
    first_in_cyc = -1; first_valid_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    build_expect();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
  endtask

  task automatic send_frame(input int stop_out, input bit hold);
    int k = 0;
    int budget = 0;
    bit hs;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = vals[0]; in_idx = idxs[0];
    while (k < NIN && out_cnt < stop_out && budget < 1000) begin
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      budget++;
      if (hs) begin
        k++;
        if (k < NIN) begin
          in_data = vals[k];
          in_idx  = idxs[k];
        end
      end
    end
    in_valid = hold;
    if (budget >= 1000) chk("send_timeout", k, NIN);
  endtask

  task automatic wait_done();
    int b = 0;
    while (!frame_done && b < 500) begin
      @(posedge clk);
      b++;
    end
    chk("done_seen", frame_done, 1);
  endtask

  task automatic frame_counts(input string tag);
    chk({tag, "_outputs"}, out_cnt, NOUT);
    chk({tag, "_inputs"}, in_cnt, NIN);
    chk({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic cmp_lit(input string name, input int lit [NOUT], input int n);
    chk({name, "_count"}, (got_q.size() >= n), 1);
    for (int i = 0; i < n && i < got_q.size(); i++)
      chk(name, got_q[i], lit[i]);
  endtask

  task automatic set_frame(input int v0, input int v1, input int v2, input int v3,
                           input int i0, input int i1, input int i2, input int i3);
    vals[0] = BW'(v0); vals[1] = BW'(v1); vals[2] = BW'(v2); vals[3] = BW'(v3);
    idxs[0] = 2'(i0);  idxs[1] = 2'(i1);  idxs[2] = 2'(i2);  idxs[3] = 2'(i3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; in_idx = '0; out_ready = 1'b1;
    in_cnt = 0; out_cnt = 0;
    first_in_cyc = -1; first_valid_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    @(posedge clk); #1 rst = 1'b0;

    // Basic frame, full throughput; idx values must not matter in nearest-neighbour mode.
    set_frame(1, 2, 3, 4, 3, 0, 1, 2);
    start_frame();
    send_frame(1000, 1'b0);
    wait_done();
    frame_counts("t1");
    chk("t1_latency", first_valid_cyc - first_in_cyc, 1);
    chk("t1_no_bubble", last_out_cyc - first_out_cyc, NOUT - 1);
`ifndef MAX_UNPOOL_IDX_EN
    cmp_lit("t1_literal", t1_lit, NOUT);
`endif
    @(negedge clk);
    chk("t1_busy_idle", busy, 0);

    // Back-pressure from a fixed pseudo-random ready pattern.
    ready_rand = 1'b1;
    start_frame();
    send_frame(1000, 1'b0);
    wait_done();
    frame_counts("t2");
`ifndef MAX_UNPOOL_IDX_EN
    cmp_lit("t2_literal", t1_lit, NOUT);
`endif
    ready_rand = 1'b0;

    // Start re-pulsed mid-frame, in_valid left high past the frame.
    set_frame(10, 20, 30, 40, 0, 1, 2, 3);
    start_frame();
    fork
      send_frame(1000, 1'b1);
      begin
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    wait_done();
    frame_counts("t3");
    repeat (8) @(negedge clk);
    chk("t3_inputs_after", in_cnt, NIN);
    chk("t3_busy_after", busy, 0);
    chk("t3_valid_after", out_valid, 0);
    @(posedge clk); #1 in_valid = 1'b0;

    // Reset after five output handshakes, then a fresh frame.
    set_frame(1, 2, 3, 4, 0, 0, 0, 0);
    start_frame();
    send_frame(5, 1'b0);
    rst = 1'b1;
    chk("t4_outs_before_reset", out_cnt, 5);
    repeat (3) begin
      @(negedge clk);
      chk_reset_outputs();
    end
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    set_frame(9, 8, 7, 6, 1, 2, 3, 0);
    start_frame();
    send_frame(1000, 1'b0);
    wait_done();
    frame_counts("t4");
`ifndef MAX_UNPOOL_IDX_EN
    cmp_lit("t4_literal", t4_lit, 4);
`endif

`ifdef MAX_UNPOOL_IDX_EN
    // Max-unpooling: one non-zero per block at its argmax position.
    set_frame(5, 6, 7, 8, 3, 0, 1, 2);
    start_frame();
    send_frame(1000, 1'b0);
    wait_done();
    frame_counts("t5");
    cmp_lit("t5_literal", t5_lit, NOUT);
`endif

    // Full-scale data values.
    set_frame(26'h3FF_FFFF, 26'h3FF_FFFF, 26'h3FF_FFFF, 26'h3FF_FFFF, 0, 1, 2, 3);
    start_frame();
    send_frame(1000, 1'b0);
    wait_done();
    frame_counts("t6");
`ifndef MAX_UNPOOL_IDX_EN
    cmp_lit("t6_literal", t6_lit, NOUT);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
